// File: rtl/pcie_ingress_ctrl.sv
// rtl/pcie_ingress_ctrl.sv - ingress buffer and push launcher ahead of the PCIe transaction-layer main FIFO
module pcie_ingress_ctrl #(
    parameter int DATA_W    = 6,
    parameter int DEPTH     = 4,
    parameter int PAUSE_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              Pausa_MF,
    output logic              push,
    output logic [DATA_W-1:0] data_in_principal,
    output logic [1:0]        state,
    output logic              error_out,
    output logic [7:0]        words_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PAUSE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SEND  = 2'b01,
        S_PAUSE = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       head_q, head_d;
    logic [AW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [7:0]          sent_q, sent_d;
    logic                push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic wr_en;
    logic launch;
    logic pause_hit;

    assign src_ready = (count_q < CW'(DEPTH)) && (state_q != S_ERROR) && !init;
    assign wr_en     = src_valid && src_ready;
    assign launch    = (state_q != S_ERROR) && !init && !Pausa_MF && (count_q != '0);

    // Datapath next state; init discards everything except the last pushed word.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pcnt_d  = pcnt_q;
        sent_d  = sent_q;
        push_d  = 1'b0;
        data_d  = data_q;
        if (init) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pcnt_d  = '0;
            sent_d  = '0;
        end else begin
            if (wr_en) begin
                tail_d = tail_q + AW'(1);
            end
            if (launch) begin
                push_d = 1'b1;
                data_d = mem_q[head_q];
                head_d = head_q + AW'(1);
                sent_d = sent_q + 8'd1;
            end
            count_d = count_q + CW'(wr_en) - CW'(launch);
            // Only cycles where backpressure actually stalls pending data count as pause.
            if (state_q != S_ERROR) begin
                pcnt_d = (Pausa_MF && (count_q != '0)) ? pcnt_q + PW'(1) : '0;
            end
        end
    end

    assign pause_hit = (state_q != S_ERROR) && !init && (pcnt_d == PW'(PAUSE_MAX));

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = S_IDLE;
        end else if (pause_hit) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_d != '0) begin
                        state_d = Pausa_MF ? S_PAUSE : S_SEND;
                    end
                end
                S_SEND: begin
                    if (count_d == '0) begin
                        state_d = S_IDLE;
                    end else if (Pausa_MF) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (!Pausa_MF) begin
                        state_d = (count_d != '0) ? S_SEND : S_IDLE;
                    end
                end
                default: state_d = S_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pcnt_q  <= '0;
            sent_q  <= '0;
            push_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            sent_q  <= sent_d;
            push_q  <= push_d;
            data_q  <= data_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= src_data;
        end
    end

    assign push              = push_q;
    assign data_in_principal = data_q;
    assign state             = state_q;
    assign error_out         = (state_q == S_ERROR);
    assign words_sent        = sent_q;

endmodule

// File: tb/tb_pcie_ingress_ctrl.sv
// tb/tb_pcie_ingress_ctrl.sv - directed and random checks of pcie_ingress_ctrl against a queue-based model
module tb_pcie_ingress_ctrl;

    localparam int DEPTH     = 4;
    localparam int PAUSE_MAX = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       src_valid = 1'b0;
    logic [5:0] src_data = '0;
    logic       src_ready;
    logic       Pausa_MF = 1'b0;
    logic       push;
    logic [5:0] data_in_principal;
    logic [1:0] state;
    logic       error_out;
    logic [7:0] words_sent;

    int compared = 0;
    int mismatched = 0;

    logic [5:0] mq [$];
    logic [5:0] pushed [$];
    int         m_sent;
    int         m_pcnt;
    logic       m_err;
    logic       m_push;
    logic [5:0] m_data;
    logic [1:0] m_state;

    pcie_ingress_ctrl #(.DATA_W(6), .DEPTH(DEPTH), .PAUSE_MAX(PAUSE_MAX)) dut (
        .clk(clk), .reset(reset), .init(init),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .Pausa_MF(Pausa_MF), .push(push), .data_in_principal(data_in_principal),
        .state(state), .error_out(error_out), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_sent  = 0;
        m_pcnt  = 0;
        m_err   = 1'b0;
        m_push  = 1'b0;
        m_state = 2'b00;
    endtask

    task automatic check_outputs();
        chk("push", push, m_push);
        if (m_push) chk("data_in_principal", data_in_principal, m_data);
        chk("state", state, m_state);
        chk("error_out", error_out, m_err);
        chk("words_sent", words_sent, m_sent[7:0]);
    endtask

    // One clock: drive inputs, check src_ready, advance the model across the edge, check outputs.
    task automatic cycle(input logic v, input logic [5:0] d, input logic p, input logic in, output logic acc);
        logic rdy;
        logic pending;
        src_valid = v;
        src_data  = d;
        Pausa_MF  = p;
        init      = in;
        #1;
        rdy = (mq.size() < DEPTH) && !m_err && !in;
        chk("src_ready", src_ready, rdy);
        acc = v && rdy;
        @(posedge clk);
        if (in) begin
            mq.delete();
            m_sent = 0;
            m_pcnt = 0;
            m_err  = 1'b0;
            m_push = 1'b0;
        end else begin
            pending = (mq.size() > 0);
            m_push = !m_err && !p && pending;
            if (m_push) begin
                m_data = mq.pop_front();
                m_sent = (m_sent + 1) % 256;
            end
            if (acc) mq.push_back(d);
            if (!m_err) begin
                m_pcnt = (p && pending) ? m_pcnt + 1 : 0;
                if (m_pcnt == PAUSE_MAX) m_err = 1'b1;
            end
        end
        m_state = m_err ? 2'b11 : (mq.size() == 0) ? 2'b00 : p ? 2'b10 : 2'b01;
        #1;
        check_outputs();
        if (push) pushed.push_back(data_in_principal);
    endtask

    logic       acc;
    int         idx;
    int         phold;
    logic       rv, rp, ri;

    initial begin
        model_clear();
        m_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_push", push, 1'b0);
        chk("rst_state", state, 2'b00);
        chk("rst_words_sent", words_sent, 8'd0);
        chk("rst_src_ready", src_ready, 1'b1);
        chk("rst_error_out", error_out, 1'b0);
        chk("rst_data", data_in_principal, 6'h00);

        // Single word
        cycle(1'b1, 6'h2A, 1'b0, 1'b0, acc);
        chk("single_state_send", state, 2'b01);
        cycle(1'b0, 6'h00, 1'b0, 1'b0, acc);
        chk("single_push", push, 1'b1);
        chk("single_data", data_in_principal, 6'h2A);
        chk("single_state_idle", state, 2'b00);
        chk("single_count", words_sent, 8'd1);
        cycle(1'b0, 6'h00, 1'b0, 1'b0, acc);

        // Burst of 1..6 with Pausa_MF high on cycles 3..6
        pushed.delete();
        idx = 1;
        for (int c = 0; c < 20; c++) begin
            cycle(idx <= 6, 6'(idx), (c >= 2 && c <= 5), 1'b0, acc);
            if (c == 5) begin
                chk("burst_full_ready", src_ready, 1'b0);
                chk("burst_pause_state", state, 2'b10);
            end
            if (acc) idx++;
        end
        chk("burst_pushed_count", pushed.size(), 6);
        for (int i = 0; i < 6 && i < pushed.size(); i++) chk("burst_order", pushed[i], i + 1);

        // Pause timeout then init recovery
        cycle(1'b1, 6'h11, 1'b1, 1'b0, acc);
        cycle(1'b1, 6'h12, 1'b1, 1'b0, acc);
        for (int c = 0; c < 20; c++) cycle(1'b0, 6'h00, 1'b1, 1'b0, acc);
        chk("timeout_state", state, 2'b11);
        chk("timeout_error", error_out, 1'b1);
        chk("timeout_ready", src_ready, 1'b0);
        chk("timeout_push", push, 1'b0);
        cycle(1'b0, 6'h00, 1'b0, 1'b1, acc);
        chk("init_state", state, 2'b00);
        chk("init_words_sent", words_sent, 8'd0);
        cycle(1'b0, 6'h00, 1'b0, 1'b0, acc);
        chk("init_empty_push", push, 1'b0);

        // init mid-burst
        for (int i = 0; i < 3; i++) cycle(1'b1, 6'(8 + i), 1'b1, 1'b0, acc);
        cycle(1'b0, 6'h00, 1'b0, 1'b1, acc);
        pushed.delete();
        for (int c = 0; c < 3; c++) cycle(1'b0, 6'h00, 1'b0, 1'b0, acc);
        chk("flush_no_push", pushed.size(), 0);
        cycle(1'b1, 6'h15, 1'b0, 1'b0, acc);
        cycle(1'b0, 6'h00, 1'b0, 1'b0, acc);
        chk("post_init_push", push, 1'b1);
        chk("post_init_data", data_in_principal, 6'h15);
        chk("post_init_count", words_sent, 8'd1);

        // Counter wrap over 257 pushes
        cycle(1'b0, 6'h00, 1'b0, 1'b1, acc);
        for (int i = 0; i < 257; i++) begin
            cycle(1'b1, 6'($urandom), 1'b0, 1'b0, acc);
            if (i == 256) chk("wrap_zero", words_sent, 8'd0);
        end
        cycle(1'b0, 6'h00, 1'b0, 1'b0, acc);
        chk("wrap_one", words_sent, 8'd1);

        // Asynchronous reset during a transfer
        cycle(1'b1, 6'h33, 1'b0, 1'b0, acc);
        cycle(1'b1, 6'h34, 1'b0, 1'b0, acc);
        chk("pre_reset_push", push, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_push", push, 1'b0);
        chk("async_rst_data", data_in_principal, 6'h00);
        chk("async_rst_count", words_sent, 8'd0);
        chk("async_rst_state", state, 2'b00);
        model_clear();
        m_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic with pause bursts and occasional init
        phold = 0;
        for (int c = 0; c < 600; c++) begin
            if (phold == 0 && $urandom_range(0, 19) == 0) phold = $urandom_range(1, 22);
            rp = (phold > 0);
            if (phold > 0) phold--;
            rv = ($urandom_range(0, 3) != 0);
            ri = ($urandom_range(0, 59) == 0);
            cycle(rv, 6'($urandom), rp, ri, acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pcie_ingress_ctrl.md
# pcie_ingress_ctrl

Ingress controller sitting directly upstream of the PCIE transaction layer's main FIFO. It accepts 6-bit words from a producer over a valid/ready handshake and buffers them in a small internal FIFO. It drives the main FIFO's push/data inputs while honouring its Pausa_MF almost-full backpressure. It reports link-side status (idle/send/pause/error), including a pause-timeout error when Pausa_MF stays asserted too long.

## Interface
- DATA_W, 6, word width (matches data_in_principal)
- DEPTH, 4, internal buffer entries, power of two ≥2
- PAUSE_MAX, 16, consecutive Pausa_MF cycles (while data is pending) that trigger ERROR
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- init  in  1  synchronous restart pulse: flush buffer, clear counter/error, go IDLE
- src_valid  in  1  producer offers src_data
- src_data  in  DATA_W  producer word
- src_ready  out  1  buffer can accept a word this cycle
- Pausa_MF  in  1  main FIFO almost-full; no new push may be launched while high
- push  out  1  registered write strobe into main FIFO
- data_in_principal  out  DATA_W  registered word into main FIFO, valid when push=1
- state  out  2  00 IDLE, 01 SEND, 10 PAUSE, 11 ERROR
- error_out  out  1  high while state==ERROR
- words_sent  out  8  count of pushes since reset/init, wraps 255→0

## Operation
- Buffer: DEPTH-entry circular FIFO, head/tail pointers of log2(DEPTH) bits with wrap, count of log2(DEPTH)+1 bits.
- src_ready = (count < DEPTH) && state != ERROR && !init; combinational from registered state only (never depends on src_valid or Pausa_MF).
- Write: src_valid && src_ready at an edge stores src_data at tail.
- Launch rule, evaluated at each edge: if state != ERROR, !init, Pausa_MF==0, count>0 → push<=1, data_in_principal<=head entry, head advances, words_sent+1. Otherwise push<=0, data_in_principal holds its last value.
- Simultaneous write and launch in the same edge: both happen; count unchanged. When full, no write occurs even if a launch frees an entry in that edge.
- State machine (next state uses count after that edge's write/launch):
  - IDLE: count>0 && !Pausa_MF → SEND; count>0 && Pausa_MF → PAUSE.
  - SEND: Pausa_MF && count>0 → PAUSE; count==0 → IDLE.
  - PAUSE: pause counter increments each cycle Pausa_MF==1; Pausa_MF==0 → SEND if count>0 else IDLE (counter cleared); counter reaching PAUSE_MAX → ERROR.
  - ERROR: sticky; push=0, src_ready=0; exits only via init (→IDLE) or reset.
- Pausa_MF high with empty buffer is not a pause: state stays IDLE, counter does not run.
- init has priority over all other activity in its edge: buffer flushed (contents discarded), pointers/count/words_sent/pause counter to 0, push<=0, state<=IDLE.

## Timing
- Reset values: push=0, data_in_principal=0, state=IDLE(00), error_out=0, words_sent=0, src_ready=1 once reset deasserts.
- Latency: word accepted at edge k is pushed at edge k+1 at earliest (push high during cycle k+1..k+2), so 1 cycle minimum.
- Throughput: one word per cycle sustained when Pausa_MF=0.
- Backpressure: Pausa_MF is sampled at the launch edge; a push already launched completes, so the main FIFO threshold must leave ≥1 free entry of slack.
- ERROR entered on the edge where pause counter reaches PAUSE_MAX; error_out asserts the following cycle with state.
- reset asserted mid-transfer: outputs go to reset values immediately (asynchronous), buffer contents lost.

## Test plan
- Reset: assert reset for 2 cycles → push=0, state=00, words_sent=0, src_ready=1, error_out=0.
- Single word: src_valid=1, src_data=6'h2A for one cycle, Pausa_MF=0 → push=1 with data_in_principal=6'h2A exactly one cycle later, state 00→01→00, words_sent=1.
- Burst with backpressure: 6 words 1..6 offered back-to-back, Pausa_MF high for cycles 3–6 → src_ready drops after buffer holds 4, state=PAUSE, push stops; words emerge in order 1..6 with no loss or duplication after release.
- Pause timeout: 2 words buffered, Pausa_MF held 16 cycles → state=11, error_out=1, src_ready=0, push=0; init pulse → state=00, buffer empty, words_sent=0.
- init mid-burst: 3 words buffered, init pulsed → no further pushes, count=0, next word accepted pushes normally.
- Counter wrap: 256 continuous words with Pausa_MF=0 → words_sent returns to 0, 257th push gives 1.
